cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed two-block 48-bit CLA.
- Splits the operands into NSEG = WIDTH/SEG_WIDTH segments and resolves one segment per pipeline stage, registering the carry between stages.
- Adds a valid/ready handshake with backpressure, ADD/SUB mode, and carry/borrow chaining for multi-word operations.
- Used by the execute and mantissa datapaths wherever wide adds must meet timing.

---
 rtl/cla_pkg.sv | 13 +
 rtl/cla_seg.sv | 39 +++
 rtl/cla_pipe_adder.sv | 124 ++++++++++++
 tb/tb_cla_pipe_adder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder family.
package cla_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } cla_op_e;

   function automatic int cla_nseg(input int width, input int seg_width);
      return width / seg_width;
   endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG_WIDTH-bit carry-lookahead slice: prefix generate/propagate,
// per-bit carries, sum, carry-out and the carry into the slice MSB.
module cla_seg #(
   parameter int SEG_WIDTH = 12
) (
   input  logic [SEG_WIDTH-1:0] a,
   input  logic [SEG_WIDTH-1:0] b,
   input  logic                 cin,
   output logic [SEG_WIDTH-1:0] sum,
   output logic                 cout,
   output logic                 c_msb
);

   logic [SEG_WIDTH-1:0] gen;
   logic [SEG_WIDTH-1:0] prop;
   logic [SEG_WIDTH-1:0] carry;
   logic                 grp_g;
   logic                 grp_p;

   assign gen  = a & b;
   assign prop = a ^ b;

   // carry[i] = G[i-1:0] | P[i-1:0] & cin, built from running group terms
   always_comb begin
      carry = '0;
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < SEG_WIDTH; i++) begin
         carry[i] = grp_g | (grp_p & cin);
         grp_g    = gen[i] | (prop[i] & grp_g);
         grp_p    = prop[i] & grp_p;
      end
   end

   assign sum   = prop ^ carry;
   assign cout  = grp_g | (grp_p & cin);
   assign c_msb = carry[SEG_WIDTH-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_WIDTH slice per stage,
// carry registered between stages, valid/ready handshake with backpressure.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH     = 48,
   parameter int SEG_WIDTH = 12
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_op,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int NSEG = cla_nseg(WIDTH, SEG_WIDTH);

   if ((SEG_WIDTH < 1) || ((WIDTH % SEG_WIDTH) != 0)) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a non-zero multiple of SEG_WIDTH");
   end

   // Operands are kept right-aligned: each stage consumes the low SEG_WIDTH
   // bits and shifts the rest down, so every stage reads the same slice.
   typedef struct packed {
      logic             carry;
      logic             ovf;
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] opa;
      logic [WIDTH-1:0] opb;
   } stage_t;

   logic [NSEG-1:0] vld_p;
   stage_t          stg_p [NSEG];
   logic [NSEG-1:0] rdy;
   cla_op_e         op_in;
   logic            inv;

   assign op_in = cla_op_e'(i_op);
   assign inv   = (op_in == OP_SUB);

   // rdy[k] = !vld_p[k] || rdy[k+1], unrolled from the output end
   always_comb begin : ready_chain
      logic acc;
      rdy = '0;
      acc = i_ready;
      for (int k = NSEG - 1; k >= 0; k--) begin
         acc    = acc | ~vld_p[k];
         rdy[k] = acc;
      end
   end

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      logic                 src_vld;
      stage_t               src;
      stage_t               nxt;
      logic [SEG_WIDTH-1:0] seg_sum;
      logic                 seg_cout;
      logic                 seg_cmsb;
      logic                 vld_q;
      stage_t               stg_q;

      if (k == 0) begin : g_head
         always_comb begin
            src       = '0;
            src_vld   = i_valid;
            src.carry = i_cin ^ inv;
            src.opa   = i_a;
            src.opb   = i_b ^ {WIDTH{inv}};
         end
      end else begin : g_body
         assign src_vld = vld_p[k-1];
         assign src     = stg_p[k-1];
      end

      cla_seg #(
         .SEG_WIDTH(SEG_WIDTH)
      ) u_seg (
         .a    (src.opa[SEG_WIDTH-1:0]),
         .b    (src.opb[SEG_WIDTH-1:0]),
         .cin  (src.carry),
         .sum  (seg_sum),
         .cout (seg_cout),
         .c_msb(seg_cmsb)
      );

      always_comb begin
         nxt                               = src;
         nxt.carry                         = seg_cout;
         nxt.ovf                           = seg_cmsb ^ seg_cout;
         nxt.sum[k*SEG_WIDTH +: SEG_WIDTH] = seg_sum;
         nxt.opa                           = src.opa >> SEG_WIDTH;
         nxt.opb                           = src.opb >> SEG_WIDTH;
      end

      // ---- stage k register boundary ----
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            vld_q <= 1'b0;
            stg_q <= '0;
         end else if (rdy[k]) begin
            vld_q <= src_vld;
            stg_q <= nxt;
         end
      end

      assign vld_p[k] = vld_q;
      assign stg_p[k] = stg_q;
   end

   assign o_ready = rdy[0];
   assign o_valid = vld_p[NSEG-1];
   assign o_sum   = stg_p[NSEG-1].sum;
   assign o_cout  = stg_p[NSEG-1].carry;
   assign o_ovf   = stg_p[NSEG-1].ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=48, SEG_WIDTH=12, four stages).
module tb_cla_pipe_adder;

   localparam int W = 48;

   typedef struct packed {
      logic         cout;
      logic         ovf;
      logic [W-1:0] sum;
   } res_t;

   localparam logic [W-1:0] ONES = {W{1'b1}};
   localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         valid = 1'b0;
   logic         ready = 1'b1;
   logic         cin   = 1'b0;
   logic         op    = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         o_ready;
   logic         o_valid;
   logic [W-1:0] o_sum;
   logic         o_cout;
   logic         o_ovf;

   res_t exp_q [$];
   int   pop_cyc [$];
   int   n_checks     = 0;
   int   n_errors     = 0;
   int   cyc          = 0;
   int   rdy_low_seen = 0;
   logic stall_prev   = 1'b0;
   res_t stall_val;

   cla_pipe_adder #(.WIDTH(W), .SEG_WIDTH(12)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .i_valid(valid),
      .o_ready(o_ready),
      .i_a    (a),
      .i_b    (b),
      .i_cin  (cin),
      .i_op   (op),
      .o_valid(o_valid),
      .i_ready(ready),
      .o_sum  (o_sum),
      .o_cout (o_cout),
      .o_ovf  (o_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic res_t mk(input logic c, input logic v, input logic [W-1:0] s);
      res_t r;
      r.cout = c;
      r.ovf  = v;
      r.sum  = s;
      return r;
   endfunction

   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sub);
      logic [W-1:0] yy;
      logic         c;
      logic [W:0]   s;
      res_t         r;
      yy     = sub ? ~y : y;
      c      = sub ? ~ci : ci;
      s      = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c};
      r.sum  = s[W-1:0];
      r.cout = s[W];
      r.ovf  = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
      return r;
   endfunction

   task automatic check_res(input string name, input res_t got, input res_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                  name, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
      end
   endtask

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Monitor: a result is taken on the next rising edge when o_valid && i_ready.
   always @(negedge clk) begin
      res_t got;
      got.cout = o_cout;
      got.ovf  = o_ovf;
      got.sum  = o_sum;
      if (!rst_n || !o_valid) begin
         stall_prev = 1'b0;
      end else if (!ready) begin
         if (stall_prev) check_res("stall_hold", got, stall_val);
         else stall_val = got;
         stall_prev = 1'b1;
      end else begin
         stall_prev = 1'b0;
         pop_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got sum=%h with empty scoreboard", o_sum);
         end else begin
            check_res("result", got, exp_q.pop_front());
         end
      end
   end

   // Must be called just after a rising edge; returns just after the accept edge.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sub);
      int t;
      a     = x;
      b     = y;
      cin   = ci;
      op    = sub;
      valid = 1'b1;
      t     = 0;
      @(negedge clk);
      while (!o_ready && t < 100) begin
         rdy_low_seen++;
         @(negedge clk);
         t++;
      end
      if (!o_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL issue_timeout: got o_ready=0, expected 1 within 100 cycles");
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   task automatic check_latency(input string name);
      int lat;
      lat = 1;
      while (!o_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_val(name, 64'(lat), 64'd4);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check_val(name, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          base;
      int          t;
      logic [95:0] a96;
      logic [95:0] b96;
      logic [95:0] bb96;
      logic [96:0] full;
      logic        c0;
      logic        c96;
      logic        c_lo;
      res_t        hi;

      repeat (3) @(posedge clk);
      #1;
      check_val("reset_valid", 64'(o_valid), 64'd0);
      check_res("reset_outputs", mk(o_cout, o_ovf, o_sum), mk(1'b0, 1'b0, '0));
      rst_n = 1'b1;
      #1;
      check_val("ready_after_reset", 64'(o_ready), 64'd1);
      @(posedge clk);
      #1;

      exp_q.push_back(mk(1'b1, 1'b0, '0));
      issue(ONES, 48'h1, 1'b0, 1'b0);
      check_latency("latency_carry_all");
      drain("drain_v1");

      exp_q.push_back(mk(1'b0, 1'b0, 48'hFFFF_FFFF_FFFE));
      issue(48'h5, 48'h7, 1'b0, 1'b1);
      exp_q.push_back(mk(1'b0, 1'b1, MSB));
      issue(MAXP, 48'h1, 1'b0, 1'b0);
      exp_q.push_back(mk(1'b1, 1'b1, MAXP));
      issue(MSB, 48'h1, 1'b0, 1'b1);
      exp_q.push_back(mk(1'b1, 1'b0, 48'h6));
      issue(48'hA, 48'h3, 1'b1, 1'b1);
      drain("drain_directed");

      // Eight back-to-back adds with a three-cycle stall on result #2
      base         = pop_cyc.size();
      rdy_low_seen = 0;
      for (int i = 1; i <= 8; i++) exp_q.push_back(mk(1'b0, 1'b0, W'(i * 'h1001)));
      fork
         begin : stream_stim
            for (int i = 1; i <= 8; i++) issue(W'(i), W'(i * 'h1000), 1'b0, 1'b0);
         end
         begin : stream_ctrl
            t = 0;
            while (pop_cyc.size() < base + 1 && t < 200) begin
               @(posedge clk);
               t++;
            end
            #1;
            ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            ready = 1'b1;
         end
      join
      drain("drain_stream");
      check_val("ready_drop_when_full", 64'(rdy_low_seen > 0), 64'd1);
      if (pop_cyc.size() >= base + 8)
         check_val("stream_throughput", 64'(pop_cyc[base+7] - pop_cyc[base+1]), 64'd6);
      else
         check_val("stream_count", 64'(pop_cyc.size() - base), 64'd8);

      // Carry through every segment while parked at stage 3, 2, 1 and 0
      for (int n = 1; n <= 4; n++) begin
         ready = 1'b0;
         for (int j = 1; j < n; j++) begin
            exp_q.push_back(mk(1'b0, 1'b0, W'(2 * j)));
            issue(W'(j), W'(j), 1'b0, 1'b0);
         end
         exp_q.push_back(mk(1'b1, 1'b0, '0));
         issue(ONES, 48'h1, 1'b0, 1'b0);
         repeat (3) @(posedge clk);
         #1;
         ready = 1'b1;
         drain("drain_stall_stage");
      end

      // 96-bit chained add/sub against a wide reference
      for (int p = 0; p < 1000; p++) begin
         a96  = {$urandom(), $urandom(), $urandom()};
         b96  = {$urandom(), $urandom(), $urandom()};
         c0   = 1'($urandom_range(0, 1));
         op   = 1'(p % 2);
         bb96 = op ? ~b96 : b96;
         c96  = op ? ~c0 : c0;
         full = {1'b0, a96} + {1'b0, bb96} + {96'b0, c96};
         hi.sum  = full[95:48];
         hi.cout = full[96];
         hi.ovf  = (a96[95] == bb96[95]) && (full[95] != a96[95]);
         exp_q.push_back(model(a96[47:0], b96[47:0], c0, op));
         issue(a96[47:0], b96[47:0], c0, op);
         t = 0;
         @(negedge clk);
         while (!(o_valid && ready) && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (!o_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL chain_low_timeout: got o_valid=0, expected 1 within 50 cycles");
         end
         c_lo = o_cout;
         @(posedge clk);
         #1;
         exp_q.push_back(hi);
         issue(a96[95:48], b96[95:48], op ? ~c_lo : c_lo, op);
         drain("drain_chain");
      end

      // Asynchronous reset with three operations in flight
      ready = 1'b0;
      issue(48'h111, 48'h222, 1'b0, 1'b0);
      issue(48'h333, 48'h444, 1'b0, 1'b0);
      issue(48'h555, 48'h666, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      check_val("inflight_head_valid", 64'(o_valid), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("async_reset_valid", 64'(o_valid), 64'd0);
      check_res("async_reset_outputs", mk(o_cout, o_ovf, o_sum), mk(1'b0, 1'b0, '0));
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check_val("no_stale_after_reset", 64'(o_valid), 64'd0);
      exp_q.push_back(mk(1'b0, 1'b0, 48'h2345_6789_ABCE));
      issue(48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b1, 1'b0);
      check_latency("latency_after_reset");
      drain("drain_after_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
